// File: rtl/line_fill_ctrl.sv
// Line fill/flush controller: turns one whole-line request into a
// sequential burst of single-word req/ack transfers on the external port.
module line_fill_ctrl #(
  parameter int LINE_BITS = 8,
  parameter int WORDS     = 64,
  parameter int AW_HI     = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [AW_HI:2]        mem_addr,
  input  logic [WORDS*32-1:0]   line_store,
  output logic [WORDS*32-1:0]   line_read,
  output logic                  mem_ready,
  output logic                  mem_done,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [AW_HI:2]        ext_addr,
  output logic [31:0]           ext_wdata,
  input  logic                  ext_ack,
  input  logic [31:0]           ext_rdata
);

  localparam int CW = $clog2(WORDS);
  localparam int BW = AW_HI - LINE_BITS + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [1:0]             state_q, state_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          base_q, base_d;
  logic [WORDS-1:0][31:0] wbuf_q;
  logic [WORDS-1:0][31:0] line_q;

  logic start_rd;
  logic start_wr;
  logic beat;
  logic last_beat;
  logic en_low;
  logic unused_ok;

  // word offset is irrelevant: bursts always start at word 0
  assign unused_ok = ^mem_addr[LINE_BITS-1:2];

  assign en_low    = !mem_r_en && !mem_w_en;
  assign start_wr  = (state_q == IDLE) && armed_q && mem_w_en;
  assign start_rd  = (state_q == IDLE) && armed_q
                     && mem_r_en && !mem_w_en;
  assign beat      = ext_req && ext_ack;
  assign last_beat = beat && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = WR_BURST;
        end else if (start_rd) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // held enables after completion must not retrigger
    if ((state_q == IDLE || state_q == DONE) && en_low) begin
      armed_d = 1'b1;
    end
    if (beat) cnt_d = cnt_q + 1'b1;
    if (start_rd || start_wr) begin
      armed_d = 1'b0;
      cnt_d   = '0;
      base_d  = mem_addr[AW_HI:LINE_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_q <= '0;
      line_q <= '0;
    end else begin
      if (start_wr) wbuf_q <= line_store;
      if (beat && state_q == RD_BURST) begin
        line_q[cnt_q] <= ext_rdata;
      end
    end
  end

  assign ext_req   = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign ext_we    = (state_q == WR_BURST);
  assign ext_addr  = {base_q, cnt_q};
  assign ext_wdata = wbuf_q[cnt_q];
  assign mem_ready = (state_q == IDLE) && armed_q;
  assign mem_done  = (state_q == DONE);
  assign line_read = line_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl with a simple external memory responder.
module tb_line_fill_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_r_en = 1'b0;
  logic          mem_w_en = 1'b0;
  logic [25:2]   mem_addr = '0;
  logic [2047:0] line_store = '0;
  logic [2047:0] line_read;
  logic          mem_ready, mem_done;
  logic          ext_req, ext_we;
  logic          ext_ack = 1'b0;
  logic [25:2]   ext_addr;
  logic [31:0]   ext_wdata, ext_rdata;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int nlog = 0;
  int done_cnt = 0;
  int wcnt = 0;
  logic [31:0] rd_base = '0;
  logic [25:2] log_addr[64];
  logic        log_we[64];
  logic [31:0] log_wdata[64];

  always #5 clk = ~clk;

  assign ext_rdata = rd_base + {26'd0, ext_addr[7:2]};

  line_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .line_store(line_store),
    .line_read(line_read), .mem_ready(mem_ready),
    .mem_done(mem_done), .ext_req(ext_req),
    .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .ext_rdata(ext_rdata)
  );

  // mode 0: no ack, 1: ack tied high, 2: ack in 2nd cycle of each word
  initial forever begin
    @(negedge clk);
    if (mode == 1) begin
      ext_ack = 1'b1;
    end else if (mode == 2) begin
      if (ext_ack) ext_ack = 1'b0;
      if (ext_req) begin
        wcnt++;
        if (wcnt == 2) begin
          ext_ack = 1'b1;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end else begin
      ext_ack = 1'b0;
    end
    if (ext_req && ext_ack) begin
      if (nlog < 64) begin
        log_addr[nlog]  = ext_addr;
        log_we[nlog]    = ext_we;
        log_wdata[nlog] = ext_wdata;
      end
      nlog++;
    end
    if (mem_done) done_cnt++;
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mem_done) break;
    end
  endtask

  task automatic test_reset;
    mode = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_ready, mem_done, ext_req, ext_we} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000",
               {mem_ready, mem_done, ext_req, ext_we});
    end
    checks++;
    if (ext_addr !== 24'h0 || ext_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_ext addr=%h wdata=%h exp=0", ext_addr, ext_wdata);
    end
    checks++;
    if (line_read !== '0) begin
      failures++;
      $display("FAIL reset_line got=%h exp=0", line_read[31:0]);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1 || ext_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack ready=%b req=%b exp=1,0", mem_ready, ext_req);
    end
  endtask

  task automatic test_read_zero_wait;
    int cyc, d0, bad;
    mode = 1;
    rd_base = 32'hA000_0000;
    nlog = 0;
    d0 = done_cnt;
    mem_addr = 24'h012345;
    mem_r_en = 1'b1;
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_ready got=%b exp=1", mem_ready);
    end
    wait_done(cyc);
    mem_r_en = 1'b0;
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL rd_latency got=%0d exp=65", cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL rd_done_cnt got=%0d exp=1", done_cnt - d0);
    end
    checks++;
    if (nlog !== 64) begin
      failures++;
      $display("FAIL rd_beats got=%0d exp=64", nlog);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_addr[i] !== 24'h012340 + 24'(i) || log_we[i] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rd_addr_walk got=%0d_bad exp=0 first=%h last=%h",
               bad, log_addr[0], log_addr[63]);
    end
    checks++;
    if (line_read[63*32 +: 32] !== 32'hA000_003F) begin
      failures++;
      $display("FAIL rd_word63 got=%h exp=a000003f", line_read[63*32 +: 32]);
    end
    checks++;
    if (line_read[31:0] !== 32'hA000_0000) begin
      failures++;
      $display("FAIL rd_word0 got=%h exp=a0000000", line_read[31:0]);
    end
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_rearm got=%b exp=1", mem_ready);
    end
  endtask

  task automatic test_write_flush;
    int cyc, d0, bad;
    @(negedge clk);
    mode = 2;
    nlog = 0;
    d0 = done_cnt;
    for (int i = 0; i < 64; i++) line_store[32*i +: 32] = 32'(i * 3);
    mem_addr = 24'h000041;
    mem_w_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ext_req !== 1'b1 || ext_we !== 1'b1) begin
      failures++;
      $display("FAIL wr_we req=%b we=%b exp=1,1", ext_req, ext_we);
    end
    line_store = '1;
    wait_done(cyc);
    mem_w_en = 1'b0;
    checks++;
    if (20 + cyc !== 129) begin
      failures++;
      $display("FAIL wr_latency got=%0d exp=129", 20 + cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nlog !== 64 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL wr_counts beats=%0d dones=%0d exp=64,1",
               nlog, done_cnt - d0);
    end
    checks++;
    if (log_wdata[10] !== 32'd30) begin
      failures++;
      $display("FAIL wr_word10 got=%h exp=1e", log_wdata[10]);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_addr[i] !== 24'h000040 + 24'(i) || log_we[i] !== 1'b1 ||
          log_wdata[i] !== 32'(i * 3)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL wr_stream got=%0d_bad exp=0 w63=%h", bad, log_wdata[63]);
    end
    checks++;
    if (line_read[63*32 +: 32] !== 32'hA000_003F) begin
      failures++;
      $display("FAIL wr_line_kept got=%h exp=a000003f",
               line_read[63*32 +: 32]);
    end
  endtask

  task automatic test_simultaneous;
    int cyc, d0;
    mode = 1;
    rd_base = 32'hB000_0000;
    nlog = 0;
    d0 = done_cnt;
    mem_addr = 24'h000200;
    mem_r_en = 1'b1;
    mem_w_en = 1'b1;
    @(negedge clk);
    checks++;
    if (ext_req !== 1'b1 || ext_we !== 1'b1) begin
      failures++;
      $display("FAIL both_we req=%b we=%b exp=1,1", ext_req, ext_we);
    end
    wait_done(cyc);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    checks++;
    if (1 + cyc !== 65) begin
      failures++;
      $display("FAIL both_latency got=%0d exp=65", 1 + cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nlog !== 64 || log_wdata[5] !== 32'hFFFF_FFFF ||
        log_addr[63] !== 24'h00023F) begin
      failures++;
      $display("FAIL both_stream beats=%0d w5=%h a63=%h exp=64,ffffffff,23f",
               nlog, log_wdata[5], log_addr[63]);
    end
    checks++;
    if (line_read[63*32 +: 32] !== 32'hA000_003F ||
        done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL both_line got=%h dones=%0d exp=a000003f,1",
               line_read[63*32 +: 32], done_cnt - d0);
    end
  endtask

  task automatic test_hold_after_done;
    int cyc, d0, bad;
    mode = 1;
    rd_base = 32'h5000_0000;
    nlog = 0;
    d0 = done_cnt;
    mem_addr = 24'h000100;
    mem_r_en = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL hold_latency got=%0d exp=65", cyc);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ready !== 1'b0 || ext_req !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_no_retrig got=%0d_bad exp=0", bad);
    end
    mem_r_en = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_rearm got=%b exp=1", mem_ready);
    end
    checks++;
    if (nlog !== 64 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL hold_counts beats=%0d dones=%0d exp=64,1",
               nlog, done_cnt - d0);
    end
  endtask

  task automatic test_spurious_and_drop;
    int cyc, d0;
    mode = 1;
    nlog = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1 || ext_req !== 1'b0 || nlog !== 0) begin
      failures++;
      $display("FAIL spur_idle ready=%b req=%b beats=%0d exp=1,0,0",
               mem_ready, ext_req, nlog);
    end
    mode = 2;
    @(negedge clk);
    rd_base = 32'hE000_0000;
    nlog = 0;
    d0 = done_cnt;
    mem_addr = 24'h000300;
    mem_r_en = 1'b1;
    repeat (11) @(negedge clk);
    mem_r_en = 1'b0;
    checks++;
    if (ext_req !== 1'b1) begin
      failures++;
      $display("FAIL drop_req got=%b exp=1", ext_req);
    end
    wait_done(cyc);
    checks++;
    if (11 + cyc !== 129) begin
      failures++;
      $display("FAIL drop_latency got=%0d exp=129", 11 + cyc);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (nlog !== 64 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL drop_counts beats=%0d dones=%0d exp=64,1",
               nlog, done_cnt - d0);
    end
    checks++;
    if (line_read[63*32 +: 32] !== 32'hE000_003F ||
        line_read[5*32 +: 32] !== 32'hE000_0005) begin
      failures++;
      $display("FAIL drop_line w63=%h w5=%h exp=e000003f,e0000005",
               line_read[63*32 +: 32], line_read[5*32 +: 32]);
    end
  endtask

  task automatic test_async_reset;
    int cyc, d0;
    mode = 1;
    rd_base = 32'hC000_0000;
    mem_addr = 24'h000400;
    mem_r_en = 1'b1;
    repeat (21) @(negedge clk);
    #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    mem_r_en = 1'b0;
    #1;
    checks++;
    if (ext_req !== 1'b0 || mem_ready !== 1'b1 || mem_done !== 1'b0) begin
      failures++;
      $display("FAIL arst_flags req=%b ready=%b done=%b exp=0,1,0",
               ext_req, mem_ready, mem_done);
    end
    checks++;
    if (line_read !== '0 || ext_addr !== 24'h0) begin
      failures++;
      $display("FAIL arst_clear w0=%h addr=%h exp=0,0",
               line_read[31:0], ext_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL arst_no_done got=%0d exp=%0d", done_cnt, d0);
    end
    rd_base = 32'hD000_0000;
    nlog = 0;
    mem_addr = 24'h000500;
    mem_r_en = 1'b1;
    wait_done(cyc);
    mem_r_en = 1'b0;
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL arst_next_latency got=%0d exp=65", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (line_read[63*32 +: 32] !== 32'hD000_003F ||
        line_read[31:0] !== 32'hD000_0000 || nlog !== 64) begin
      failures++;
      $display("FAIL arst_next_line w63=%h w0=%h beats=%0d exp=d000003f,d0000000,64",
               line_read[63*32 +: 32], line_read[31:0], nlog);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_flush();
    test_simultaneous();
    test_hold_after_done();
    test_spurious_and_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
